hex_stack_engine: RTL

// Producer side of the 60-bit `numbers` digit bus that the VGA display path renders as 15 hex digits.

---
 rtl/hex_stack_if.sv | 12 +
 rtl/hex_stack_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hex_stack_if.sv
// Command port of the hex stack engine: valid/ready handshake carrying an opcode and a PUSH operand.
interface hex_stack_if #(
  parameter int W = 4
);
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   op_code;
  logic [W-1:0] op_data;

  modport master (output op_valid, output op_code, output op_data, input op_ready);
  modport slave  (input op_valid, input op_code, input op_data, output op_ready);
endinterface

// File: rtl/hex_stack_engine.sv
// Hex operand stack behind a valid/ready command port; the stack is copied onto the
// numbers display bus only on a v_sync falling edge so each frame shows a consistent stack.
module hex_stack_engine #(
  parameter int DEPTH = 15,
  parameter int W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  hex_stack_if.slave         cmd,
  input  logic               vga_v_sync_i,
  output logic [DEPTH*W-1:0] numbers_o,
  output logic [3:0]         count_o,
  output logic [1:0]         err_o
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_SWAP  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  localparam logic [3:0] FULL      = 4'(DEPTH);
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_OVER  = 2'b01;
  localparam logic [1:0] ERR_UNDER = 2'b10;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [W-1:0]       data_q;
  logic [W-1:0]       stack_q [DEPTH];
  logic [W-1:0]       stack_d [DEPTH];
  logic [W-1:0]       shift_dn [DEPTH];
  logic [W-1:0]       shift_up [DEPTH];
  logic [3:0]         count_q, count_d;
  logic [1:0]         err_q, err_d;
  logic               vsync_q;
  logic [DEPTH*W-1:0] numbers_q;
  logic [DEPTH*W-1:0] stack_flat;
  logic               accept;
  logic [W-1:0]       arith_res;
  logic [2*W-1:0]     prod;

  // shift_dn makes room at the top (push/dup), shift_up closes the gap left by a pop/reduction
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stack
      if (gi == 0) begin : g_top
        assign shift_dn[gi] = '0;
      end else begin : g_lower
        assign shift_dn[gi] = stack_q[gi-1];
      end
      if (gi == DEPTH - 1) begin : g_bottom
        assign shift_up[gi] = '0;
      end else begin : g_upper
        assign shift_up[gi] = stack_q[gi+1];
      end
      assign stack_flat[gi*W +: W] = stack_q[gi];
    end
  endgenerate

  assign prod = {{W{1'b0}}, stack_q[1]} * {{W{1'b0}}, stack_q[0]};

  always_comb begin
    arith_res = prod[W-1:0];
    case (op_q)
      OP_ADD:  arith_res = stack_q[1] + stack_q[0];
      OP_SUB:  arith_res = stack_q[1] - stack_q[0];
      default: arith_res = prod[W-1:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cmd.op_ready = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd.op_ready = 1'b1;
        if (cmd.op_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stack_d[i] = stack_q[i];
    count_d = count_q;
    err_d   = err_q;
    if (state_q == EXEC) begin
      case (op_q)
        OP_PUSH, OP_DUP: begin
          if (count_q == FULL) begin
            err_d = ERR_OVER;
          end else if (op_q == OP_DUP && count_q == 4'd0) begin
            err_d = ERR_UNDER;
          end else begin
            for (int i = 0; i < DEPTH; i++) stack_d[i] = shift_dn[i];
            stack_d[0] = (op_q == OP_PUSH) ? data_q : stack_q[0];
            count_d    = count_q + 4'd1;
          end
        end
        OP_POP: begin
          if (count_q == 4'd0) begin
            err_d = ERR_UNDER;
          end else begin
            for (int i = 0; i < DEPTH; i++) stack_d[i] = shift_up[i];
            count_d = count_q - 4'd1;
          end
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          if (count_q < 4'd2) begin
            err_d = ERR_UNDER;
          end else begin
            for (int i = 0; i < DEPTH; i++) stack_d[i] = shift_up[i];
            stack_d[0] = arith_res;
            count_d    = count_q - 4'd1;
          end
        end
        OP_SWAP: begin
          if (count_q < 4'd2) begin
            err_d = ERR_UNDER;
          end else begin
            stack_d[0] = stack_q[1];
            stack_d[1] = stack_q[0];
          end
        end
        default: begin
          for (int i = 0; i < DEPTH; i++) stack_d[i] = '0;
          count_d = 4'd0;
          err_d   = ERR_OK;
        end
      endcase
    end
  end

  // Snapshot uses stack_q, so a commit on the detection edge shows up one frame later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      data_q    <= '0;
      count_q   <= '0;
      err_q     <= ERR_OK;
      vsync_q   <= 1'b1;
      numbers_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= cmd.op_code;
        data_q <= cmd.op_data;
      end
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
      count_q <= count_d;
      err_q   <= err_d;
      vsync_q <= vga_v_sync_i;
      if (vsync_q && !vga_v_sync_i) numbers_q <= stack_flat;
    end
  end

  assign numbers_o = numbers_q;
  assign count_o   = count_q;
  assign err_o     = err_q;

endmodule
